mux_scan_capture: RTL and testbench

- Sequencer/deserializer paired with the 8:1 single-bit multiplexer (Multiplexer_8).
- Drives the mux Sel/Enable inputs and steps through channels 0..7; samples MuxOut once per channel after a programmable settle time.
- Assembles the 8 sampled bits into a parallel word and hands it downstream with a one-cycle Done pulse.
- Used wherever a bank of 8 single-bit sources (pixel/flag lines) must be gathered into a byte.

---
 rtl/mux_scan_capture_if.sv | 33 +++
 rtl/mux_scan_capture.sv | 114 +++++++++++
 tb/tb_mux_scan_capture.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_capture_if.sv
// Handshake/bus bundle between mux_scan_capture and its environment.
// master drives Start/Abort/MuxOut; slave (the sequencer) drives the rest.
interface mux_scan_capture_if;
  logic       Start;
  logic       Abort;
  logic       MuxOut;
  logic [2:0] Sel;
  logic       MuxEnable;
  logic       Busy;
  logic       Done;
  logic [7:0] Word;
`ifdef SCAN_PARITY_EN
  logic       Parity;

  modport master (
    output Start, Abort, MuxOut,
    input  Sel, MuxEnable, Busy, Done, Word, Parity
  );
  modport slave (
    input  Start, Abort, MuxOut,
    output Sel, MuxEnable, Busy, Done, Word, Parity
  );
`else
  modport master (
    output Start, Abort, MuxOut,
    input  Sel, MuxEnable, Busy, Done, Word
  );
  modport slave (
    input  Start, Abort, MuxOut,
    output Sel, MuxEnable, Busy, Done, Word
  );
`endif
endinterface

// File: rtl/mux_scan_capture.sv
// Scan sequencer for an 8:1 bit mux: steps Sel 0..7, samples MuxOut
// after SETTLE extra cycles per channel, then publishes an 8-bit Word.
// Ports: Clock, Reset (sync, active-high), bus (mux_scan_capture_if.slave):
//   in Start/Abort/MuxOut; out Sel/MuxEnable/Busy/Done/Word[/Parity].
// Option macro SCAN_PARITY_EN adds Parity = ^Word, registered with Word.
module mux_scan_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic Clock,
  input  logic Reset,
  mux_scan_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state_q;
  logic [2:0] sel_q;
  logic [3:0] cnt_q;
  logic [6:0] shadow_q;
  logic [7:0] word_q;
  logic       en_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] word_d;

  // Channel 7 is taken straight from MuxOut so Word updates in one edge.
  assign word_d = {bus.MuxOut, shadow_q};

`ifdef SCAN_PARITY_EN
  logic parity_q;
  assign bus.Parity = parity_q;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 7'd0;
      word_q   <= 8'h00;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // Abort beats a simultaneous Start.
          if (bus.Start && !bus.Abort) begin
            state_q  <= SCAN;
            sel_q    <= 3'd0;
            cnt_q    <= SETTLE_C;
            shadow_q <= 7'd0;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SCAN: begin
          if (bus.Abort) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 7'd0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (sel_q != 3'd7) begin
            shadow_q[sel_q] <= bus.MuxOut;
            sel_q           <= sel_q + 3'd1;
            cnt_q           <= SETTLE_C;
          end else begin
            word_q  <= word_d;
`ifdef SCAN_PARITY_EN
            parity_q <= ^word_d;
`endif
            state_q <= DONE;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 3'd0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Sel       = sel_q;
  assign bus.MuxEnable = en_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Word      = word_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Self-checking bench for mux_scan_capture (SETTLE=1 and SETTLE=0).
// Mux model: MuxOut = MuxEnable ? src[Sel] : 0.
module tb_mux_scan_capture;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] src1;
  logic [7:0] src0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_scan_capture_if if1 ();
  mux_scan_capture_if if0 ();

  assign if1.MuxOut = if1.MuxEnable ? src1[if1.Sel] : 1'b0;
  assign if0.MuxOut = if0.MuxEnable ? src0[if0.Sel] : 1'b0;

  mux_scan_capture #(.SETTLE(1)) u1 (
    .Clock (clk),
    .Reset (rst),
    .bus   (if1.slave)
  );

  mux_scan_capture #(.SETTLE(0)) u0 (
    .Clock (clk),
    .Reset (rst),
    .bus   (if0.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.Start = 1'b0; if1.Abort = 1'b0;
    if0.Start = 1'b0; if0.Abort = 1'b0;
    src1 = 8'hA5; src0 = 8'hA5;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (if1.Word !== 8'h00 || if1.Sel !== 3'd0 ||
          if1.MuxEnable !== 1'b0 || if1.Busy !== 1'b0 ||
          if1.Done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d word=%h sel=%0d en=%b busy=%b done=%b want 00/0/0/0/0",
                 i, if1.Word, if1.Sel, if1.MuxEnable, if1.Busy, if1.Done);
      end
      n_chk++;
      if (if0.Word !== 8'h00 || if0.Busy !== 1'b0 || if0.Done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle0 cyc=%0d word=%h busy=%b done=%b want 00/0/0",
                 i, if0.Word, if0.Busy, if0.Done);
      end
    end
  endtask

  // Full scan with SETTLE=1: each channel held 2 cycles, Done after edge 16.
  task automatic test_scan_settle1();
    int esel, een, ebusy, edone;
    src1 = 8'hA5;
    if1.Start = 1'b1;
    tick();
    if1.Start = 1'b0;
    for (int e = 0; e <= 18; e++) begin
      if (e > 0) tick();
      esel = (e < 16) ? e / 2 : 0;
      een = (e < 16) ? 1 : 0;
      ebusy = (e <= 16) ? 1 : 0;
      edone = (e == 16) ? 1 : 0;
      n_chk++;
      if (if1.Sel !== 3'(esel) || if1.MuxEnable !== 1'(een) ||
          if1.Busy !== 1'(ebusy) || if1.Done !== 1'(edone)) begin
        n_fail++;
        $display("FAIL scan1 edge=%0d sel/en/busy/done=%0d/%b/%b/%b want %0d/%0d/%0d/%0d",
                 e, if1.Sel, if1.MuxEnable, if1.Busy, if1.Done,
                 esel, een, ebusy, edone);
      end
      n_chk++;
      if (if1.Word !== ((e < 16) ? 8'h00 : 8'hA5)) begin
        n_fail++;
        $display("FAIL scan1_word edge=%0d got=%h want=%h",
                 e, if1.Word, (e < 16) ? 8'h00 : 8'hA5);
      end
    end
  endtask

  // SETTLE=0 with Start held: Done at edges 8, 18, 28.
  task automatic test_back_to_back();
    int dn[$];
    src0 = 8'h3C;
    if0.Start = 1'b1;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (if0.Done === 1'b1) begin
        dn.push_back(e);
        n_chk++;
        if (if0.Word !== 8'h3C) begin
          n_fail++;
          $display("FAIL b2b_word edge=%0d got=%h want=3c", e, if0.Word);
        end
      end
    end
    if0.Start = 1'b0;
    n_chk++;
    if (dn.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d want=3", dn.size());
    end else begin
      n_chk++;
      if (dn[0] != 8 || dn[1] != 18) begin
        n_fail++;
        $display("FAIL b2b_edges got=%0d,%0d want=8,18", dn[0], dn[1]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_abort();
    int nd = 0;
    src1 = 8'hA5;
    if1.Start = 1'b1;
    tick();
    if1.Start = 1'b0;
    repeat (17) tick();
    n_chk++;
    if (if1.Word !== 8'hA5) begin
      n_fail++;
      $display("FAIL abort_pre got=%h want=a5", if1.Word);
    end
    src1 = 8'hFF;
    if1.Start = 1'b1;
    tick();
    if1.Start = 1'b0;
    repeat (6) tick();
    if1.Abort = 1'b1;
    tick();
    if1.Abort = 1'b0;
    n_chk++;
    if (if1.Busy !== 1'b0 || if1.MuxEnable !== 1'b0 ||
        if1.Sel !== 3'd0 || if1.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle busy/en/sel/done=%b/%b/%0d/%b want 0/0/0/0",
               if1.Busy, if1.MuxEnable, if1.Sel, if1.Done);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.Done === 1'b1) nd++;
    end
    n_chk++;
    if (nd != 0 || if1.Word !== 8'hA5) begin
      n_fail++;
      $display("FAIL abort_nodone dones=%0d word=%h want 0/a5", nd, if1.Word);
    end
    if1.Start = 1'b1;
    if1.Abort = 1'b1;
    tick();
    if1.Start = 1'b0;
    if1.Abort = 1'b0;
    n_chk++;
    if (if1.Busy !== 1'b0 || if1.MuxEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start busy=%b en=%b want 0/0",
               if1.Busy, if1.MuxEnable);
    end
    tick();
  endtask

  task automatic test_start_during_busy();
    int nd = 0;
    src1 = 8'h5A;
    if1.Start = 1'b1;
    tick();
    if1.Start = 1'b0;
    repeat (4) tick();
    if1.Start = 1'b1;
    tick();
    if1.Start = 1'b0;
    repeat (10) tick();
    n_chk++;
    if (if1.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_early done=%b at edge 15 want 0", if1.Done);
    end
    tick();
    n_chk++;
    if (if1.Done !== 1'b1 || if1.Word !== 8'h5A) begin
      n_fail++;
      $display("FAIL busy_start_done done=%b word=%h want 1/5a",
               if1.Done, if1.Word);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.Done === 1'b1 || if1.Busy === 1'b1) nd++;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL busy_start_queued active_cycles=%0d want 0", nd);
    end
  endtask

  task automatic test_reset_midscan();
    int nd = 0;
    src1 = 8'hC3;
    if1.Start = 1'b1;
    tick();
    if1.Start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (if1.Word !== 8'h00 || if1.Busy !== 1'b0 || if1.Sel !== 3'd0 ||
        if1.MuxEnable !== 1'b0 || if1.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid word=%h busy=%b sel=%0d en=%b done=%b want 00/0/0/0/0",
               if1.Word, if1.Busy, if1.Sel, if1.MuxEnable, if1.Done);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.Done === 1'b1) nd++;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL rst_mid_done dones=%0d want 0", nd);
    end
  endtask

  // Sources change every cycle; bit k must be the value of source k
  // just before edge (k+1)*(SETTLE+1).
  task automatic test_random();
    int s, p, lat, got;
    bit w;
    logic [7:0] exp, r, wd;
    for (int it = 0; it < 24; it++) begin
      w = 1'($urandom_range(0, 1));
      s = w ? 1 : 0;
      p = s + 1;
      lat = 8 * p;
      exp = 8'h00;
      got = -1;
      repeat ($urandom_range(0, 3)) tick();
      r = 8'($urandom);
      if (w) begin src1 = r; if1.Start = 1'b1; end
      else begin src0 = r; if0.Start = 1'b1; end
      tick();
      if1.Start = 1'b0;
      if0.Start = 1'b0;
      for (int e = 1; e <= lat + 4 && got < 0; e++) begin
        r = 8'($urandom);
        if (w) src1 = r; else src0 = r;
        if (e <= lat && e % p == 0) exp[e / p - 1] = r[e / p - 1];
        tick();
        if ((w ? if1.Done : if0.Done) === 1'b1) got = e;
      end
      wd = w ? if1.Word : if0.Word;
      n_chk++;
      if (got != lat) begin
        n_fail++;
        $display("FAIL rand_latency it=%0d settle=%0d got=%0d want=%0d",
                 it, s, got, lat);
      end
      n_chk++;
      if (wd !== exp) begin
        n_fail++;
        $display("FAIL rand_word it=%0d settle=%0d got=%h want=%h",
                 it, s, wd, exp);
      end
`ifdef SCAN_PARITY_EN
      n_chk++;
      if ((w ? if1.Parity : if0.Parity) !== ^exp) begin
        n_fail++;
        $display("FAIL rand_parity it=%0d got=%b want=%b",
                 it, w ? if1.Parity : if0.Parity, ^exp);
      end
`endif
      tick();
    end
  endtask

`ifdef SCAN_PARITY_EN
  task automatic test_parity();
    logic [7:0] pat [2];
    pat[0] = 8'h07;
    pat[1] = 8'h0F;
    for (int i = 0; i < 2; i++) begin
      src0 = pat[i];
      if0.Start = 1'b1;
      tick();
      if0.Start = 1'b0;
      repeat (8) tick();
      n_chk++;
      if (if0.Done !== 1'b1 || if0.Word !== pat[i] ||
          if0.Parity !== ^pat[i]) begin
        n_fail++;
        $display("FAIL parity pat=%h done=%b word=%h par=%b want 1/%h/%b",
                 pat[i], if0.Done, if0.Word, if0.Parity, pat[i], ^pat[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_settle1();
    test_back_to_back();
    test_abort();
    test_start_during_busy();
    test_reset_midscan();
    test_random();
`ifdef SCAN_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
